sha1_padder: RTL and testbench

Upstream message-formatting stage for the SHA-1 core: accepts the message as a byte stream and applies SHA-1 padding (0x80, zero fill, 64-bit big-endian bit length). Emits complete 512-bit blocks in the word order the core's `block` input expects, with a valid/ready handshake. Produces one or two padded final blocks per message and flags the final one so downstream control knows when the digest is complete.

---
 rtl/sha1_padder.sv | 147 ++++++++++++++
 tb/tb_sha1_padder.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha1_padder.sv
// SHA-1 message padder: byte stream in, padded 512-bit blocks out (W0 at [31:0]).
// Define SHA1_PADDER_ERR_EN to add the sticky byte-counter overflow flag on err.
module sha1_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [511:0] out_block,
  output logic         out_valid,
  output logic         out_last,
  input  logic         out_ready
`ifdef SHA1_PADDER_ERR_EN
  ,
  output logic         err
`endif
);

  localparam int CW = LEN_W - 3;

  typedef enum logic [1:0] {S_FILL, S_PAD, S_EMIT, S_LEN} state_t;

  state_t        r_state;
  logic [7:0]    r_buf [64];
  logic [5:0]    r_idx;
  logic [CW-1:0] r_cnt;
  logic          r_final;
  logic          r_pend_pad;
  logic          r_need_len;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          r_out_last;
  logic [63:0]   w_len;
  logic          w_acc;
  logic          w_cons;

  // bit length = byte count * 8, zero-extended to the 64-bit field
  assign w_len     = 64'({r_cnt, 3'b000});
  assign w_acc     = in_valid && r_in_ready;
  assign w_cons    = r_out_valid && out_ready;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

  // byte k lands big-endian inside word k/4
  for (genvar k = 0; k < 64; k++) begin : g_map
    assign out_block[32*(k/4) + 8*(3-(k%4)) +: 8] = r_buf[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_FILL;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_final     <= 1'b0;
      r_pend_pad  <= 1'b0;
      r_need_len  <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      for (int j = 0; j < 64; j++) r_buf[j] <= 8'h00;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_acc) begin
            r_buf[r_idx] <= in_data;
            r_idx        <= r_idx + 6'd1;
            r_cnt        <= r_cnt + CW'(1);
            if (r_idx == 6'd63) begin
              r_final     <= 1'b0;
              r_pend_pad  <= in_last;
              r_state     <= S_EMIT;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_last  <= 1'b0;
            end else if (in_last) begin
              r_state    <= S_PAD;
              r_in_ready <= 1'b0;
            end
          end
        end
        S_PAD: begin
          for (int j = 0; j < 64; j++) begin
            if (j == int'(r_idx))     r_buf[j] <= 8'h80;
            else if (j > int'(r_idx)) r_buf[j] <= 8'h00;
          end
          if (r_idx <= 6'd55) begin
            for (int j = 56; j < 64; j++) r_buf[j] <= w_len[8*(63-j) +: 8];
            r_final    <= 1'b1;
            r_out_last <= 1'b1;
          end else begin
            r_need_len <= 1'b1;
            r_out_last <= 1'b0;
          end
          r_state     <= S_EMIT;
          r_out_valid <= 1'b1;
        end
        S_EMIT: begin
          if (w_cons) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (r_final) begin
              r_idx      <= '0;
              r_cnt      <= '0;
              r_final    <= 1'b0;
              r_pend_pad <= 1'b0;
              r_need_len <= 1'b0;
              r_state    <= S_FILL;
              r_in_ready <= 1'b1;
            end else if (r_pend_pad) begin
              r_idx      <= '0;
              r_pend_pad <= 1'b0;
              r_state    <= S_PAD;
            end else if (r_need_len) begin
              r_need_len <= 1'b0;
              r_state    <= S_LEN;
            end else begin
              r_state    <= S_FILL;
              r_in_ready <= 1'b1;
            end
          end
        end
        S_LEN: begin
          for (int j = 0; j < 56; j++) r_buf[j] <= 8'h00;
          for (int j = 56; j < 64; j++) r_buf[j] <= w_len[8*(63-j) +: 8];
          r_final     <= 1'b1;
          r_out_last  <= 1'b1;
          r_out_valid <= 1'b1;
          r_state     <= S_EMIT;
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

`ifdef SHA1_PADDER_ERR_EN
  // sticky: set when the byte counter rolls over from all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    err <= 1'b0;
    else if (w_acc && (&r_cnt)) err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_sha1_padder.sv
// Testbench for sha1_padder: random messages against a byte-level padding model.
// With SHA1_PADDER_ERR_EN the DUT is built with LEN_W=16 and the overflow flag is tested.
module tb_sha1_padder;
`ifdef SHA1_PADDER_ERR_EN
  localparam int TB_LEN_W = 16;
`else
  localparam int TB_LEN_W = 64;
`endif

  typedef byte unsigned bq_t[$];

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [511:0] out_block;
  logic         out_valid;
  logic         out_last;
  logic         out_ready;
`ifdef SHA1_PADDER_ERR_EN
  logic         err;
`endif

  int checks = 0;
  int errors = 0;
  bit rand_rdy = 1'b0;
  int gap_pct = 0;

  logic [511:0] got_blk[$];
  bit           got_last[$];
  logic [511:0] exp_blk[$];
  bit           exp_last[$];

  always #5 clk = ~clk;

  sha1_padder #(.LEN_W(TB_LEN_W)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_block(out_block), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready)
`ifdef SHA1_PADDER_ERR_EN
    , .err(err)
`endif
  );

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got_blk.push_back(out_block);
      got_last.push_back(out_last);
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 99) < 60);
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks", checks);
    $fatal(1, "watchdog");
  end

  // Reference: append 0x80, zero-fill to 56 mod 64, append 64-bit big-endian bit length.
  task automatic model(input bq_t m);
    bq_t p;
    longint unsigned bits;
    int nb;
    logic [511:0] w;
    p = m;
    bits = longint'(m.size()) * 8;
    if (TB_LEN_W < 64) bits = bits & ((64'd1 << TB_LEN_W) - 64'd1);
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      w = '0;
      for (int k = 0; k < 64; k++) w[32*(k/4) + 8*(3-(k%4)) +: 8] = p[64*b + k];
      exp_blk.push_back(w);
      exp_last.push_back(b == nb - 1);
    end
  endtask

  task automatic clear_q();
    got_blk.delete(); got_last.delete();
    exp_blk.delete(); exp_last.delete();
  endtask

  task automatic send_msg(input bq_t m, input bit mark_last, output bit ok);
    bit acc;
    int to;
    ok = 1'b1;
    for (int i = 0; i < m.size(); i++) begin
      acc = 1'b0;
      to = 0;
      while (!acc) begin
        @(negedge clk);
        in_valid = ($urandom_range(0, 99) >= gap_pct);
        in_data  = in_valid ? m[i] : 8'($urandom);
        in_last  = in_valid ? (mark_last && (i == m.size() - 1)) : 1'($urandom);
        acc = in_valid && in_ready;
        @(posedge clk);
        to++;
        if (to > 3000) begin
          ok = 1'b0;
          in_valid = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_blocks(input int n, output bit ok);
    int cyc;
    cyc = 0;
    while (got_blk.size() < n && cyc < 4000) begin
      @(posedge clk);
      cyc++;
    end
    ok = (got_blk.size() >= n);
    repeat (8) @(posedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
    checks++; if (out_block !== 512'd0) begin errors++; $display("FAIL reset_out_block: got %h expected 0", out_block); end
`ifdef SHA1_PADDER_ERR_EN
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
`endif
  endtask

  task automatic test_abc();
    bq_t m;
    bit ok;
    logic [511:0] b;
    m = '{8'h61, 8'h62, 8'h63};
    clear_q();
    model(m);
    send_msg(m, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abc_send_timeout: got timeout expected accept"); end
    wait_blocks(1, ok);
    checks++; if (got_blk.size() !== 1) begin errors++; $display("FAIL abc_count: got %0d expected 1", got_blk.size()); end
    b = (got_blk.size() > 0) ? got_blk[0] : 'x;
    checks++; if (b !== exp_blk[0]) begin errors++; $display("FAIL abc_model: got %h expected %h", b, exp_blk[0]); end
    checks++; if (b[31:0] !== 32'h61626380) begin errors++; $display("FAIL abc_w0: got %h expected 61626380", b[31:0]); end
    checks++; if (b[479:32] !== 448'd0) begin errors++; $display("FAIL abc_w1_14: got %h expected 0", b[479:32]); end
    checks++; if (b[511:480] !== 32'h00000018) begin errors++; $display("FAIL abc_w15: got %h expected 00000018", b[511:480]); end
    checks++; if (got_last.size() < 1 || got_last[0] !== 1'b1) begin errors++; $display("FAIL abc_last: got %0d blocks / last wrong, expected last=1", got_last.size()); end
  endtask

  task automatic test_boundaries();
    bq_t m;
    bit ok;
    logic [511:0] b0, b1;
    // 55 zero bytes: padding and length fit in one block
    m.delete();
    for (int i = 0; i < 55; i++) m.push_back(8'h00);
    clear_q(); model(m); send_msg(m, 1'b1, ok); wait_blocks(1, ok);
    checks++; if (got_blk.size() !== 1) begin errors++; $display("FAIL b55_count: got %0d expected 1", got_blk.size()); end
    b0 = (got_blk.size() > 0) ? got_blk[0] : 'x;
    checks++; if (b0[423:416] !== 8'h80) begin errors++; $display("FAIL b55_byte55: got %h expected 80", b0[423:416]); end
    checks++; if (b0[511:480] !== 32'h000001B8) begin errors++; $display("FAIL b55_w15: got %h expected 000001b8", b0[511:480]); end
    checks++; if (b0 !== exp_blk[0] || got_last[0] !== 1'b1) begin errors++; $display("FAIL b55_model: got %h expected %h", b0, exp_blk[0]); end
    // 56 bytes: length spills into a second block
    m.delete();
    for (int i = 0; i < 56; i++) m.push_back(8'($urandom));
    clear_q(); model(m); send_msg(m, 1'b1, ok); wait_blocks(2, ok);
    checks++; if (got_blk.size() !== 2) begin errors++; $display("FAIL b56_count: got %0d expected 2", got_blk.size()); end
    b0 = (got_blk.size() > 0) ? got_blk[0] : 'x;
    b1 = (got_blk.size() > 1) ? got_blk[1] : 'x;
    checks++; if (b0[479:472] !== 8'h80 || b0[471:448] !== 24'd0 || b0[511:480] !== 32'd0) begin errors++; $display("FAIL b56_pad: got %h expected 80 then zeros", b0[511:448]); end
    checks++; if (b1[479:0] !== 480'd0 || b1[511:480] !== 32'h000001C0) begin errors++; $display("FAIL b56_len_block: got %h expected W15=000001c0 rest 0", b1); end
    checks++; if (got_last.size() < 2 || got_last[0] !== 1'b0 || got_last[1] !== 1'b1) begin errors++; $display("FAIL b56_last: got %0d blocks, expected last pattern 0,1", got_last.size()); end
    checks++; if (b0 !== exp_blk[0] || b1 !== exp_blk[1]) begin errors++; $display("FAIL b56_model: got %h expected %h", b0, exp_blk[0]); end
    // 64 bytes with last on the 64th: pad-only second block
    m.delete();
    for (int i = 0; i < 64; i++) m.push_back(8'($urandom));
    clear_q(); model(m); send_msg(m, 1'b1, ok); wait_blocks(2, ok);
    checks++; if (got_blk.size() !== 2) begin errors++; $display("FAIL b64_count: got %0d expected 2", got_blk.size()); end
    b0 = (got_blk.size() > 0) ? got_blk[0] : 'x;
    b1 = (got_blk.size() > 1) ? got_blk[1] : 'x;
    checks++; if (b1[31:0] !== 32'h80000000 || b1[511:480] !== 32'h00000200 || b1[479:32] !== 448'd0) begin errors++; $display("FAIL b64_second: got %h expected W0=80000000 W15=00000200", b1); end
    checks++; if (got_last.size() < 2 || got_last[0] !== 1'b0 || got_last[1] !== 1'b1) begin errors++; $display("FAIL b64_last: got %0d blocks, expected last pattern 0,1", got_last.size()); end
    checks++; if (b0 !== exp_blk[0]) begin errors++; $display("FAIL b64_first: got %h expected %h", b0, exp_blk[0]); end
  endtask

  task automatic test_stall();
    bq_t m;
    bit ok;
    int cyc;
    logic [511:0] held;
    m.delete();
    for (int i = 0; i < 20; i++) m.push_back(8'($urandom));
    clear_q(); model(m);
    rand_rdy = 1'b0;
    out_ready = 1'b0;
    send_msg(m, 1'b1, ok);
    cyc = 0;
    while (!out_valid && cyc < 50) begin @(negedge clk); cyc++; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid_timeout: got %b expected 1", out_valid); end
    held = out_block;
    checks++; if (held !== exp_blk[0]) begin errors++; $display("FAIL stall_block: got %h expected %h", held, exp_blk[0]); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_block !== held || in_ready !== 1'b0) begin
        errors++; $display("FAIL stall_hold: cycle %0d valid=%b in_ready=%b block_changed=%b expected valid=1 in_ready=0 unchanged", i, out_valid, in_ready, out_block !== held);
      end
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drop: got %b expected 0", out_valid); end
    checks++; if (got_blk.size() !== 1) begin errors++; $display("FAIL stall_count: got %0d expected 1", got_blk.size()); end
    out_ready = 1'b1;
  endtask

  task automatic test_random();
    bq_t m;
    bit ok;
    rand_rdy = 1'b1;
    gap_pct = 30;
    for (int t = 0; t < 8; t++) begin
      m.delete();
      for (int i = 0; i < $urandom_range(1, 150); i++) m.push_back(8'($urandom));
      clear_q(); model(m);
      send_msg(m, 1'b1, ok);
      wait_blocks(exp_blk.size(), ok);
      checks++; if (got_blk.size() !== exp_blk.size()) begin errors++; $display("FAIL rand_count: len %0d got %0d expected %0d", m.size(), got_blk.size(), exp_blk.size()); end
      for (int b = 0; b < exp_blk.size() && b < got_blk.size(); b++) begin
        checks++; if (got_blk[b] !== exp_blk[b] || got_last[b] !== exp_last[b]) begin
          errors++; $display("FAIL rand_block: len %0d blk %0d last %b/%b got %h expected %h", m.size(), b, got_last[b], exp_last[b], got_blk[b], exp_blk[b]);
        end
      end
    end
    rand_rdy = 1'b0;
    gap_pct = 0;
    @(posedge clk); #1 out_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    bq_t m1, m2;
    bit ok;
    for (int i = 0; i < 60; i++) m1.push_back(8'($urandom));
    for (int i = 0; i < 7; i++) m2.push_back(8'($urandom));
    clear_q(); model(m1); model(m2);
    send_msg(m1, 1'b1, ok);
    send_msg(m2, 1'b1, ok);
    wait_blocks(exp_blk.size(), ok);
    checks++; if (got_blk.size() !== exp_blk.size()) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", got_blk.size(), exp_blk.size()); end
    for (int b = 0; b < exp_blk.size() && b < got_blk.size(); b++) begin
      checks++; if (got_blk[b] !== exp_blk[b] || got_last[b] !== exp_last[b]) begin
        errors++; $display("FAIL b2b_block: blk %0d got %h expected %h", b, got_blk[b], exp_blk[b]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bq_t m;
    bit ok;
    for (int i = 0; i < 30; i++) m.push_back(8'($urandom));
    clear_q();
    send_msg(m, 1'b0, ok);
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midrst_state: valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
    rst = 1'b0;
    repeat (4) @(posedge clk);
    checks++; if (got_blk.size() !== 0) begin errors++; $display("FAIL midrst_no_block: got %0d expected 0", got_blk.size()); end
    m = '{8'h61, 8'h62, 8'h63};
    clear_q(); model(m);
    send_msg(m, 1'b1, ok);
    wait_blocks(1, ok);
    checks++; if (got_blk.size() !== 1) begin errors++; $display("FAIL midrst_count: got %0d expected 1", got_blk.size()); end
    checks++; if (got_blk.size() < 1 || got_blk[0] !== exp_blk[0] || got_blk[0][31:0] !== 32'h61626380 || got_last[0] !== 1'b1) begin
      errors++; $display("FAIL midrst_abc: got %h expected %h", (got_blk.size() > 0) ? got_blk[0] : 'x, exp_blk[0]);
    end
  endtask

`ifdef SHA1_PADDER_ERR_EN
  task automatic test_err_wrap();
    bq_t full, head, tail;
    bit ok;
    for (int i = 0; i < 8193; i++) full.push_back(8'($urandom));
    for (int i = 0; i < 8191; i++) head.push_back(full[i]);
    tail.push_back(full[8191]);
    tail.push_back(full[8192]);
    do_reset();
    clear_q(); model(full);
    send_msg(head, 1'b0, ok);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_before_wrap: got %b expected 0", err); end
    send_msg(tail, 1'b1, ok);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_after_wrap: got %b expected 1", err); end
    wait_blocks(exp_blk.size(), ok);
    checks++; if (got_blk.size() !== exp_blk.size()) begin errors++; $display("FAIL err_count: got %0d expected %0d", got_blk.size(), exp_blk.size()); end
    checks++; if (got_blk.size() < 1 || got_blk[got_blk.size()-1][511:480] !== 32'h00000008) begin
      errors++; $display("FAIL err_w15: got %0d blocks, expected final W15=00000008");
    end
    checks++; if (got_blk.size() < 1 || got_blk[got_blk.size()-1] !== exp_blk[exp_blk.size()-1]) begin errors++; $display("FAIL err_final_model: final block differs from model"); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = 8'h00;
    #2;
    test_reset();
    test_abc();
    test_boundaries();
    test_stall();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef SHA1_PADDER_ERR_EN
    test_err_wrap();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
